// File: rtl/line_trig_pkg.sv
// Shared constants for the line trigger shaper: FSM state encoding and
// trigger synchroniser depth.
package line_trig_pkg;

  localparam int SYNC_STAGES = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PULSE   = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

endpackage

// File: rtl/line_trig_shaper_toggle_edge_det.sv
// Toggle-coded trigger to single-cycle event converter. Both level changes of
// i_toggle produce one registered event pulse.
module toggle_edge_det
  import line_trig_pkg::*;
(
  input  logic fclk,
  input  logic rst,
  input  logic i_toggle,
  output logic o_event
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_event;

  // Reset preloads the delay line with the live input so release is quiet.
  always_ff @(posedge fclk) begin
    if (rst) begin
      r_sync  <= {SYNC_STAGES{i_toggle}};
      r_event <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_toggle};
      r_event <= r_sync[SYNC_STAGES-1] ^ r_sync[SYNC_STAGES-2];
    end
  end

  assign o_event = r_event;

endmodule

// File: rtl/line_trig_shaper.sv
// Camera Link CC1 line trigger shaper with frame gating and holdoff.
// Optional saturating overrun counter enabled by LINE_TRIG_OVERRUN_CNT_EN.
module line_trig_shaper
  import line_trig_pkg::*;
#(
  parameter int PW_W  = 16,
  parameter int PER_W = 32,
  parameter int LN_W  = 16
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic             trigToggle,
  input  logic             enable,
  input  logic [PW_W-1:0]  pulseWidth,
  input  logic [PER_W-1:0] minPeriod,
  input  logic [LN_W-1:0]  linesPerFrame,
  output logic             cc1Out,
  output logic             fvalOut,
  output logic [LN_W-1:0]  lineCount,
  output logic [LN_W-1:0]  overrunCount,
  output logic             busy
);

  logic             w_event;
  logic             w_accept;
  logic [PW_W-1:0]  w_pw_eff;
  logic             w_pulse_done;
  logic             w_hold_done;
  logic             w_frame_full;
  logic             w_close_on_accept;

  logic [1:0]       r_state;
  logic [PW_W-1:0]  r_pw_lat;
  logic [PW_W-1:0]  r_pw_cnt;
  logic [PER_W-1:0] r_mp_lat;
  logic [PER_W-1:0] r_per_cnt;
  logic [LN_W-1:0]  r_lpf_lat;
  logic [LN_W-1:0]  r_line;
  logic             r_fval;

  logic             r_cc1_o;
  logic             r_fval_o;
  logic [LN_W-1:0]  r_line_o;
  logic             r_busy_o;

  toggle_edge_det u_edge_det (
    .fclk     (fclk),
    .rst      (rst),
    .i_toggle (trigToggle),
    .o_event  (w_event)
  );

  assign w_accept     = w_event && (r_state == ST_IDLE) && enable;
  assign w_pw_eff     = (pulseWidth == {PW_W{1'b0}}) ? PW_W'(1) : pulseWidth;
  assign w_pulse_done = (r_pw_cnt >= r_pw_lat);
  // Widened compare so minPeriod of 0 does not underflow.
  assign w_hold_done  = (({1'b0, r_per_cnt} + (PER_W+1)'(1)) >= {1'b0, r_mp_lat});
  assign w_frame_full = (r_lpf_lat != {LN_W{1'b0}}) && (r_line == r_lpf_lat);
  assign w_close_on_accept = r_fval && (linesPerFrame != {LN_W{1'b0}}) &&
                             (r_line >= linesPerFrame);

  // Main FSM: pulse timing, holdoff and frame/line bookkeeping.
  always_ff @(posedge fclk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pw_lat  <= {PW_W{1'b0}};
      r_pw_cnt  <= {PW_W{1'b0}};
      r_mp_lat  <= {PER_W{1'b0}};
      r_per_cnt <= {PER_W{1'b0}};
      r_lpf_lat <= {LN_W{1'b0}};
      r_line    <= {LN_W{1'b0}};
      r_fval    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_PULSE;
            r_pw_lat  <= w_pw_eff;
            r_mp_lat  <= minPeriod;
            r_lpf_lat <= linesPerFrame;
            r_pw_cnt  <= PW_W'(1);
            r_per_cnt <= {PER_W{1'b0}};
            r_fval    <= 1'b1;
            r_line    <= w_close_on_accept ? LN_W'(1) : (r_line + LN_W'(1));
          end else if (!enable) begin
            r_fval <= 1'b0;
            r_line <= {LN_W{1'b0}};
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_PULSE: begin
          if (r_per_cnt != {PER_W{1'b1}}) begin
            r_per_cnt <= r_per_cnt + PER_W'(1);
          end else begin
            r_per_cnt <= r_per_cnt;
          end
          if (w_pulse_done) begin
            r_state <= ST_HOLDOFF;
            if (w_frame_full) begin
              r_fval <= 1'b0;
              r_line <= {LN_W{1'b0}};
            end else begin
              r_fval <= r_fval;
            end
          end else begin
            r_pw_cnt <= r_pw_cnt + PW_W'(1);
          end
        end
        ST_HOLDOFF: begin
          if (r_per_cnt != {PER_W{1'b1}}) begin
            r_per_cnt <= r_per_cnt + PER_W'(1);
          end else begin
            r_per_cnt <= r_per_cnt;
          end
          if (w_hold_done) begin
            r_state <= ST_IDLE;
            if (!enable) begin
              r_fval <= 1'b0;
              r_line <= {LN_W{1'b0}};
            end else begin
              r_fval <= r_fval;
            end
          end else begin
            r_state <= ST_HOLDOFF;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LINE_TRIG_OVERRUN_CNT_EN
  logic            w_reject;
  logic [LN_W-1:0] r_ovr;

  assign w_reject = w_event && !w_accept;

  // Saturating count of requests that could not start a pulse.
  always_ff @(posedge fclk) begin
    if (rst) begin
      r_ovr <= {LN_W{1'b0}};
    end else if (w_reject && (r_ovr != {LN_W{1'b1}})) begin
      r_ovr <= r_ovr + LN_W'(1);
    end else begin
      r_ovr <= r_ovr;
    end
  end

  assign overrunCount = r_ovr;
`else
  assign overrunCount = {LN_W{1'b0}};
`endif

  // Output stage; keeps cc1Out and fvalOut edges aligned.
  always_ff @(posedge fclk) begin
    if (rst) begin
      r_cc1_o  <= 1'b0;
      r_fval_o <= 1'b0;
      r_line_o <= {LN_W{1'b0}};
      r_busy_o <= 1'b0;
    end else begin
      r_cc1_o  <= (r_state == ST_PULSE);
      r_fval_o <= r_fval;
      r_line_o <= r_line;
      r_busy_o <= (r_state != ST_IDLE);
    end
  end

  assign cc1Out    = r_cc1_o;
  assign fvalOut   = r_fval_o;
  assign lineCount = r_line_o;
  assign busy      = r_busy_o;

endmodule

// File: tb/tb_line_trig_shaper.sv
// Self-checking bench for line_trig_shaper: directed scenarios plus randomized
// toggle trains scored against an arithmetic acceptance model.
module tb_line_trig_shaper;

  localparam int PW_W  = 16;
  localparam int PER_W = 32;
  localparam int LN_W  = 16;
`ifdef LINE_TRIG_OVERRUN_CNT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic             fclk = 1'b0;
  logic             rst = 1'b1;
  logic             trigToggle = 1'b0;
  logic             enable = 1'b0;
  logic [PW_W-1:0]  pulseWidth = '0;
  logic [PER_W-1:0] minPeriod = '0;
  logic [LN_W-1:0]  linesPerFrame = '0;
  logic             cc1Out;
  logic             fvalOut;
  logic [LN_W-1:0]  lineCount;
  logic [LN_W-1:0]  overrunCount;
  logic             busy;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int rises = 0;
  int hi_cnt = 0;
  logic prev_cc1 = 1'b0;

  line_trig_shaper #(.PW_W(PW_W), .PER_W(PER_W), .LN_W(LN_W)) dut (
    .fclk          (fclk),
    .rst           (rst),
    .trigToggle    (trigToggle),
    .enable        (enable),
    .pulseWidth    (pulseWidth),
    .minPeriod     (minPeriod),
    .linesPerFrame (linesPerFrame),
    .cc1Out        (cc1Out),
    .fvalOut       (fvalOut),
    .lineCount     (lineCount),
    .overrunCount  (overrunCount),
    .busy          (busy)
  );

  always #5 fclk = ~fclk;

  always @(posedge fclk) cyc <= cyc + 1;

  // Pulse monitor: counts rising edges and high cycles of cc1Out.
  always @(negedge fclk) begin
    if (cc1Out && !prev_cc1) rises <= rises + 1;
    if (cc1Out) hi_cnt <= hi_cnt + 1;
    prev_cc1 <= cc1Out;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge fclk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic toggle();
    trigToggle = ~trigToggle;
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int k;
    k = 0;
    while (busy === 1'b1 && k < lim) begin
      tick(1);
      k++;
    end
    chk(tag, busy, 1'b0);
  endtask

  // Toggle train with configuration fixed; the model accepts a request when its
  // decision cycle (3 cycles after the toggle is driven) is not before next_ok.
  task automatic run_seq(input string tag, input int n, input int glo, input int ghi,
                         input int pw, input int mp);
    longint next_ok, d;
    int acc, rej, r0, h0, pwp, hold, gap;
    do_reset();
    pulseWidth    = PW_W'(pw);
    minPeriod     = PER_W'(mp);
    linesPerFrame = '0;
    enable        = 1'b1;
    tick(1);
    r0 = rises;
    h0 = hi_cnt;
    acc = 0;
    rej = 0;
    pwp = (pw == 0) ? 1 : pw;
    hold = (pwp > mp - 1) ? pwp : mp - 1;
    next_ok = 0;
    for (int i = 0; i < n; i++) begin
      toggle();
      d = longint'(cyc) + 3;
      if (d >= next_ok) begin
        acc++;
        next_ok = d + hold + 2;
      end else begin
        rej++;
      end
      gap = $urandom_range(ghi, glo);
      tick(gap);
    end
    tick(4);
    wait_idle({tag, "_idle"}, 500);
    tick(2);
    chk({tag, "_lines"}, lineCount, acc);
    chk({tag, "_ovr"}, overrunCount, OVR_EN ? rej : 0);
    chk({tag, "_rises"}, rises - r0, acc);
    chk({tag, "_hicyc"}, hi_cnt - h0, acc * pwp);
    chk({tag, "_fval"}, fvalOut, acc > 0);
  endtask

  initial begin
    int r0;

    // Reset values
    trigToggle = 1'b1;
    tick(3);
    chk("rst_cc1", cc1Out, 1'b0);
    chk("rst_fval", fvalOut, 1'b0);
    chk("rst_lines", lineCount, 0);
    chk("rst_ovr", overrunCount, 0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick(6);
    chk("rst_release_cc1", cc1Out, 1'b0);
    chk("rst_release_busy", busy, 1'b0);

    // Single pulse: width 10, starts 3 cycles after the sampling edge
    do_reset();
    pulseWidth = 16'd10; minPeriod = 32'd100; linesPerFrame = '0; enable = 1'b1;
    tick(2);
    toggle();
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      chk($sformatf("single_cc1_k%0d", k), cc1Out, (k >= 4 && k <= 13));
      if (k == 4) chk("single_busy", busy, 1'b1);
    end
    chk("single_lines", lineCount, 1);
    chk("single_fval", fvalOut, 1'b1);
    wait_idle("single_idle", 200);

    // Toggles 40 cycles apart against a 100-cycle minimum period
    run_seq("spacing40", 6, 40, 40, 10, 100);

    // Frame of 4 lines followed by a fifth pulse opening a new frame
    do_reset();
    pulseWidth = 16'd5; minPeriod = 32'd20; linesPerFrame = 16'd4; enable = 1'b1;
    tick(2);
    for (int i = 1; i <= 5; i++) begin
      toggle();
      tick(4);
      chk($sformatf("frame_p%0d_cc1", i), cc1Out, 1'b1);
      chk($sformatf("frame_p%0d_lines", i), lineCount, (i == 5) ? 1 : i);
      chk($sformatf("frame_p%0d_fval", i), fvalOut, 1'b1);
      tick(4);
      tick(1);
      chk($sformatf("frame_p%0d_end_cc1", i), cc1Out, 1'b0);
      chk($sformatf("frame_p%0d_end_fval", i), fvalOut, (i != 4));
      chk($sformatf("frame_p%0d_end_lines", i), lineCount, (i == 4) ? 0 : ((i == 5) ? 1 : i));
      tick(31);
    end

    // Zero pulse width gives a one-cycle pulse
    do_reset();
    pulseWidth = '0; minPeriod = '0; linesPerFrame = '0; enable = 1'b1;
    tick(2);
    toggle();
    tick(3);
    chk("pw0_k3", cc1Out, 1'b0);
    tick(1);
    chk("pw0_k4", cc1Out, 1'b1);
    tick(1);
    chk("pw0_k5", cc1Out, 1'b0);
    tick(5);

    // Zero minimum period: spacing bounded by pulse width
    run_seq("mp0_gap7", 3, 7, 7, 5, 0);
    run_seq("mp0_gap6", 4, 6, 6, 5, 0);

    // Enable dropped mid-pulse
    do_reset();
    pulseWidth = 16'd10; minPeriod = 32'd30; linesPerFrame = '0; enable = 1'b1;
    tick(2);
    toggle();
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      chk($sformatf("endrop_cc1_k%0d", k), cc1Out, (k >= 4 && k <= 13));
      if (k == 6) enable = 1'b0;
    end
    wait_idle("endrop_idle", 100);
    tick(2);
    chk("endrop_fval", fvalOut, 1'b0);
    chk("endrop_lines", lineCount, 0);
    r0 = rises;
    toggle();
    tick(8);
    chk("endrop_ovr", overrunCount, OVR_EN ? 1 : 0);
    chk("endrop_nopulse", rises - r0, 0);
    chk("endrop_busy", busy, 1'b0);

    // Reset asserted mid-pulse
    do_reset();
    pulseWidth = 16'd10; minPeriod = 32'd30; linesPerFrame = '0; enable = 1'b1;
    tick(2);
    toggle();
    tick(6);
    chk("midrst_pre_cc1", cc1Out, 1'b1);
    rst = 1'b1;
    tick(1);
    chk("midrst_cc1", cc1Out, 1'b0);
    chk("midrst_fval", fvalOut, 1'b0);
    chk("midrst_lines", lineCount, 0);
    chk("midrst_ovr", overrunCount, 0);
    chk("midrst_busy", busy, 1'b0);
    toggle();
    tick(2);
    rst = 1'b0;
    r0 = rises;
    tick(10);
    chk("midrst_nopulse", rises - r0, 0);
    chk("midrst_rel_busy", busy, 1'b0);
    chk("midrst_rel_lines", lineCount, 0);

    // Randomized toggle trains
    for (int rep = 0; rep < 3; rep++) begin
      run_seq($sformatf("rnd%0d", rep), 20, 3, 150,
              $urandom_range(20, 0), $urandom_range(120, 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
